// File: rtl/alpu_seq_ctrl.sv
// alpu_seq_ctrl
// Sequencer for the ALU + 4-entry operand cache execution unit. Takes one
// decoded instruction at a time, reads source A and source B from the cache,
// holds them on the ALU for ALU_LATENCY cycles, writes the result back to the
// destination entry and retires it with a done_o pulse. It also owns the carry
// flag that feeds the ALU carry-in.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid_i/ready_o      instruction handshake (ready only in IDLE)
//   instr_i, op1_i/op2_i/opd_i opcode, source A/B and destination indices
//   cache_*                    single-cycle request strobe, address, write
//                              data/enable; read data/valid and write ack back
//   alu_*                      opcode, operands and carry-in to the ALU;
//                              result and carry-out back
//   done_o, result_o           retire pulse; result held until next retire
//   err_o                      abort pulse (index out of range or timeout)
module alpu_seq_ctrl #(
   parameter int REG_WIDTH        = 4,
   parameter int OPERAND_WIDTH    = 4,
   parameter int CACHE_ADDR_WIDTH = 2,
   parameter int ALU_LATENCY      = 1,
   parameter int TIMEOUT          = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        instr_valid_i,
   output logic                        instr_ready_o,
   input  logic [3:0]                  instr_i,
   input  logic [OPERAND_WIDTH-1:0]    op1_i,
   input  logic [OPERAND_WIDTH-1:0]    op2_i,
   input  logic [OPERAND_WIDTH-1:0]    opd_i,
   output logic [CACHE_ADDR_WIDTH-1:0] cache_addr_o,
   output logic [REG_WIDTH-1:0]        cache_wdata_o,
   output logic                        cache_ce_o,
   output logic                        cache_we_o,
   input  logic [REG_WIDTH-1:0]        cache_rdata_i,
   input  logic                        cache_rvalid_i,
   input  logic                        cache_wack_i,
   output logic [3:0]                  alu_instr_o,
   output logic [REG_WIDTH-1:0]        alu_a_o,
   output logic [REG_WIDTH-1:0]        alu_b_o,
   output logic                        alu_cin_o,
   input  logic [REG_WIDTH-1:0]        alu_out_i,
   input  logic                        alu_cout_i,
   output logic                        done_o,
   output logic [REG_WIDTH-1:0]        result_o,
   output logic                        err_o
);

   // Wait counter only has to hold 0..TIMEOUT-1, latency counter 0..ALU_LATENCY-1.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_EXEC, S_WR, S_WAIT_W
   } state_t;

   state_t                      state_q;
   logic                        ready_q;
   logic                        ce_q;
   logic                        we_q;
   logic                        done_q;
   logic                        err_q;
   logic [CACHE_ADDR_WIDTH-1:0] addr_q;
   logic [REG_WIDTH-1:0]        wdata_q;
   logic [3:0]                  instr_q;
   logic [OPERAND_WIDTH-1:0]    op1_q;
   logic [OPERAND_WIDTH-1:0]    op2_q;
   logic [OPERAND_WIDTH-1:0]    opd_q;
   logic [REG_WIDTH-1:0]        a_q;
   logic [REG_WIDTH-1:0]        b_q;
   logic [REG_WIDTH-1:0]        res_q;     // ALU result of the instruction in flight
   logic                        cout_q;    // carry-out waiting for retirement
   logic                        cin_q;     // architectural carry flag
   logic [REG_WIDTH-1:0]        result_q;  // last retired result
   logic [TW-1:0]               wait_cnt_q;
   logic [LW-1:0]               lat_cnt_q;

   logic idx_oor;
   logic wait_expired;

   // Any index bit above the cache address range makes the instruction illegal.
   assign idx_oor = ((op1_i >> CACHE_ADDR_WIDTH) != '0) ||
                    ((op2_i >> CACHE_ADDR_WIDTH) != '0) ||
                    ((opd_i >> CACHE_ADDR_WIDTH) != '0);

   assign wait_expired = (wait_cnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b1;
         ce_q       <= 1'b0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         instr_q    <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         opd_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         cout_q     <= 1'b0;
         cin_q      <= 1'b0;
         result_q   <= '0;
         wait_cnt_q <= '0;
         lat_cnt_q  <= '0;
      end else begin
         // Strobes are single-cycle: they default low and are raised only on
         // the transition into the state that owns them.
         ce_q   <= 1'b0;
         we_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               if (instr_valid_i) begin
                  instr_q <= instr_i;
                  op1_q   <= op1_i;
                  op2_q   <= op2_i;
                  opd_q   <= opd_i;
                  if (idx_oor) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q <= S_RD_A;
                     ready_q <= 1'b0;
                     ce_q    <= 1'b1;
                     addr_q  <= op1_i[CACHE_ADDR_WIDTH-1:0];
                  end
               end
            end

            S_RD_A: begin
               state_q    <= S_WAIT_A;
               wait_cnt_q <= '0;
            end

            S_WAIT_A: begin
               if (cache_rvalid_i) begin
                  a_q <= cache_rdata_i;
                  if (op1_q == op2_q) begin
                     // Same source twice: reuse the first read for B.
                     b_q       <= cache_rdata_i;
                     state_q   <= S_EXEC;
                     lat_cnt_q <= LW'(ALU_LATENCY - 1);
                  end else begin
                     state_q <= S_RD_B;
                     ce_q    <= 1'b1;
                     addr_q  <= op2_q[CACHE_ADDR_WIDTH-1:0];
                  end
               end else if (wait_expired) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TW'(1);
               end
            end

            S_RD_B: begin
               state_q    <= S_WAIT_B;
               wait_cnt_q <= '0;
            end

            S_WAIT_B: begin
               if (cache_rvalid_i) begin
                  b_q       <= cache_rdata_i;
                  state_q   <= S_EXEC;
                  lat_cnt_q <= LW'(ALU_LATENCY - 1);
               end else if (wait_expired) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TW'(1);
               end
            end

            S_EXEC: begin
               // Operands stay on the ALU until the last latency cycle; the
               // carry-out is parked in cout_q until the write is acknowledged.
               if (lat_cnt_q == '0) begin
                  res_q   <= alu_out_i;
                  cout_q  <= alu_cout_i;
                  state_q <= S_WR;
                  ce_q    <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= opd_q[CACHE_ADDR_WIDTH-1:0];
                  wdata_q <= alu_out_i;
               end else begin
                  lat_cnt_q <= lat_cnt_q - LW'(1);
               end
            end

            S_WR: begin
               state_q    <= S_WAIT_W;
               wait_cnt_q <= '0;
            end

            S_WAIT_W: begin
               if (cache_wack_i) begin
                  state_q  <= S_IDLE;
                  ready_q  <= 1'b1;
                  done_q   <= 1'b1;
                  result_q <= res_q;
                  cin_q    <= cout_q;
               end else if (wait_expired) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TW'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign instr_ready_o = ready_q;
   assign cache_ce_o    = ce_q;
   assign cache_we_o    = we_q;
   assign cache_addr_o  = addr_q;
   assign cache_wdata_o = wdata_q;
   assign alu_instr_o   = instr_q;
   assign alu_a_o       = a_q;
   assign alu_b_o       = b_q;
   assign alu_cin_o     = cin_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign result_o      = result_q;

endmodule

// File: doc/alpu_seq_ctrl.md
# alpu_seq_ctrl

Sequencer for the ALU-plus-register-cache execution unit. Accepts one decoded instruction at a time from the instruction queue. For each instruction it reads both source operands from the 4-entry operand cache, drives the ALU, and writes the result back to the cache. It also owns the carry flag, so the ALU carry-in is always the carry-out of the previous instruction.

## Interface

Parameters:
- REG_WIDTH, 4, data width of ALU operands, results and cache entries
- OPERAND_WIDTH, 4, width of the op1/op2/opd operand indices
- CACHE_ADDR_WIDTH, 2, cache address width (4 entries)
- ALU_LATENCY, 1, cycles from stable ALU inputs to valid out/cout (≥1)
- TIMEOUT, 15, maximum wait cycles for rvalid/wack before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid_i  in  1  instruction queue has an instruction
- instr_ready_o  out  1  controller can accept (high only in IDLE)
- instr_i  in  4  ALU opcode
- op1_i, op2_i, opd_i  in  OPERAND_WIDTH each  source A, source B, destination indices
- cache_addr_o  out  CACHE_ADDR_WIDTH  cache address
- cache_wdata_o  out  REG_WIDTH  write data
- cache_ce_o  out  1  cache request strobe (single-cycle)
- cache_we_o  out  1  write enable, qualified by ce
- cache_rdata_i  in  REG_WIDTH  read data
- cache_rvalid_i  in  1  read data valid
- cache_wack_i  in  1  write acknowledge
- alu_instr_o  out  4  opcode to ALU
- alu_a_o, alu_b_o  out  REG_WIDTH  ALU operands
- alu_cin_o  out  1  carry flag register
- alu_out_i  in  REG_WIDTH  ALU result
- alu_cout_i  in  1  ALU carry-out
- done_o  out  1  one-cycle pulse, instruction retired
- result_o  out  REG_WIDTH  retired result, valid with done_o, held until the next done_o
- err_o  out  1  one-cycle pulse, instruction aborted

## Operation

- States: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, EXEC, WR, WAIT_W.
- IDLE
  - instr_ready_o=1.
  - On instr_valid_i&instr_ready_o, latch instr, op1, op2 and opd.
  - Range check: if the upper bits of any index (bits above CACHE_ADDR_WIDTH) are nonzero, pulse err_o next cycle and stay in IDLE.
  - Otherwise go to RD_A.
- RD_A: cache_ce_o=1, we=0, addr=op1[CACHE_ADDR_WIDTH-1:0]; go to WAIT_A.
- WAIT_A
  - On rvalid, capture rdata into the A register.
  - Then go to RD_B, or go straight to EXEC with B=A when op1==op2 (the second read is skipped).
- RD_B / WAIT_B: same as RD_A / WAIT_A, using op2 and the B register.
- EXEC
  - alu_a_o, alu_b_o and alu_instr_o are held stable for ALU_LATENCY cycles (down-counter).
  - In the last cycle, capture alu_out_i into the result register and alu_cout_i into the carry flag.
  - Go to WR.
- WR: cache_ce_o=1, we=1, addr=opd, wdata=result; go to WAIT_W.
- WAIT_W: on wack, pulse done_o with result_o in the next cycle and go to IDLE.
- Timeout: in WAIT_* states a counter increments each cycle. Reaching TIMEOUT:
  - err_o pulse, return to IDLE.
  - Carry flag and result_o are unchanged.
  - The destination entry is not written.
- The carry flag is updated only by completed instructions. alu_cin_o is the flag register, constant for the whole instruction.
- rvalid/wack seen outside the matching WAIT state are ignored.
- cache_ce_o is never high for two consecutive cycles.

## Timing

- Reset values, applied at the first edge with reset=1:
  - State IDLE; instr_ready_o=1.
  - cache_ce_o, cache_we_o, done_o and err_o all 0.
  - cache_addr_o, cache_wdata_o, alu_a_o, alu_b_o, alu_instr_o and result_o all 0.
  - alu_cin_o=0; counters 0.
- Reset mid-operation abandons the instruction. No write is issued, and a late rvalid/wack is ignored.
- Zero-wait cache (response the cycle after ce), ALU_LATENCY=1, acceptance edge E:
  - RD_A c1, WAIT_A c2, RD_B c3, WAIT_B c4, EXEC c5, WR c6, WAIT_W c7.
  - done_o and instr_ready_o are high in c8.
  - A new instruction presented in c8 is accepted at the end of c8.
  - Throughput is 1 instruction per 8 cycles.
- op1==op2 removes 2 cycles: done_o in c6.
- Each extra ALU_LATENCY cycle and each cache wait cycle adds one cycle.
- done_o and err_o are mutually exclusive and never both high.

## Test plan

- Cache preloaded [0]=3, [1]=5, carry=0; ADD op1=0 op2=1 opd=2 → reads addr 0 then 1, alu_a=3, alu_b=5, write [2]=8, done_o in c8, result_o=8.
- Carry chain, 4-bit: [0]=0xF, [1]=0x1; ADD → [2]=0x0, carry=1. Then ADD [1]+[1] with op1==op2 → one read only, alu_cin_o=1, result 0x3, done_o in c6.
- rvalid delayed 3 cycles on the op1 read → done_o delayed by exactly 3 cycles; cache_ce_o not re-asserted while waiting.
- rvalid never returned → err_o pulse after TIMEOUT wait cycles, no write issued, carry unchanged, instr_ready_o=1 the next cycle.
- op2_i=4'b0100 (out of range) → err_o the cycle after acceptance, no cache access.
- reset=1 asserted during EXEC → next cycle all outputs at reset values; a subsequent wack is ignored; the next instruction sees alu_cin_o=0.
